// File: rtl/ccu_snoop_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ccu_snoop_arbiter_pkg
// Shared types for the CCU snoop arbiter: requester index type, snoop port
// request/response structs (AC/CR/CD channels) and a CR decode helper.
// ---------------------------------------------------------------------------
package ccu_snoop_arbiter_pkg;

  localparam int unsigned NumSnoopSrc = 2;
  localparam int unsigned AddrWidth   = 32;
  localparam int unsigned DataWidth   = 64;

  // Requester index: 0 = read-snoop path, 1 = write-snoop path.
  typedef logic ccu_snoop_src_t;

  typedef logic [4:0] cr_resp_t;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [3:0]           snoop;
    logic [2:0]           prot;
  } ac_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    cr_resp_t cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  } snoop_resp_t;

  // CRRESP[0] is DataTransfer: a CD burst follows this response.
  function automatic logic cr_data_transfer(input cr_resp_t resp);
    return resp[0];
  endfunction

endpackage

// File: rtl/ccu_snoop_arbiter_if.sv
// ---------------------------------------------------------------------------
// ccu_snoop_arbiter_if
// Bundles the two controller-side snoop ports and the crossbar-side snoop
// port. The slave modport is the arbiter's view; the master modport is the
// view of the surrounding controllers and crossbar.
//   slv_req  : requests from controllers (index 0 read, 1 write)
//   slv_resp : responses to controllers
//   mst_req  : request towards the snoop crossbar
//   mst_resp : response from the snoop crossbar
// ---------------------------------------------------------------------------
interface ccu_snoop_arbiter_if;
  import ccu_snoop_arbiter_pkg::*;

  snoop_req_t  [NumSnoopSrc-1:0] slv_req;
  snoop_resp_t [NumSnoopSrc-1:0] slv_resp;
  snoop_req_t                    mst_req;
  snoop_resp_t                   mst_resp;

  modport slave  (input  slv_req, mst_resp, output slv_resp, mst_req);
  modport master (output slv_req, mst_resp, input  slv_resp, mst_req);
endinterface

// File: rtl/ccu_snoop_route_fifo.sv
// ---------------------------------------------------------------------------
// ccu_snoop_route_fifo
// Small in-order FIFO of requester indices used to route CR/CD responses.
//   clk_i/rst_i : clock, asynchronous active-high reset (empties the FIFO)
//   push_i      : push data_i (ignored when full)
//   data_i      : requester index to record
//   pop_i       : drop the head entry (ignored when empty)
//   full_o      : no free slot
//   empty_o     : no entry
//   head_o      : oldest recorded index
// ---------------------------------------------------------------------------
module ccu_snoop_route_fifo
  import ccu_snoop_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  ccu_snoop_src_t data_i,
  input  logic           pop_i,
  output logic           full_o,
  output logic           empty_o,
  output ccu_snoop_src_t head_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_s, pop_s;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? {PtrW{1'b0}} : ptr + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == {CntW{1'b0}});
  assign head_o  = mem_q[rd_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    push_s = push_i && !full_o;
    pop_s  = pop_i && !empty_o;
    if (push_s) begin
      mem_d[wr_q] = data_i;
      wr_d        = ptr_inc(wr_q);
    end else begin
      wr_d = wr_q;
    end
    if (pop_s) begin
      rd_d = ptr_inc(rd_q);
    end else begin
      rd_d = rd_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= {DEPTH{1'b0}};
      wr_q  <= {PtrW{1'b0}};
      rd_q  <= {PtrW{1'b0}};
      cnt_q <= {CntW{1'b0}};
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ccu_snoop_arbiter.sv
// ---------------------------------------------------------------------------
// ccu_snoop_arbiter
// Shares one snoop port between the CCU read- and write-snoop controllers.
// AC is arbitrated round-robin (combinational pass-through); CR and CD are
// routed back in AC order using two index FIFOs.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   bus           : slv_req/slv_resp (controllers), mst_req/mst_resp (crossbar)
//   outstanding_o : AC handshakes whose CR has not yet completed
//   proto_err_o   : high in each cycle an orphan CR or CD is presented
// ---------------------------------------------------------------------------
module ccu_snoop_arbiter
  import ccu_snoop_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned MAX_CD_PENDING  = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  ccu_snoop_arbiter_if.slave                 bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               proto_err_o
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING) + 1;

  ccu_snoop_src_t rr_q, rr_d, lock_idx_q, lock_idx_d, grant_s;
  logic           lock_q, lock_d;
  logic [OutW-1:0] out_q, out_d;

  logic cr_full_s, cr_empty_s, cd_full_s, cd_empty_s;
  ccu_snoop_src_t cr_head_s, cd_head_s;
  logic ac_valid_s, ac_hs_s, cr_hs_s, cd_hs_s, cr_dt_s;

  snoop_req_t                    mst_req_s;
  snoop_resp_t [NumSnoopSrc-1:0] slv_resp_s;

  // Grant select: a stalled AC keeps its grantee, otherwise prefer rr_q.
  always_comb begin
    grant_s = rr_q;
    if (lock_q) begin
      grant_s = lock_idx_q;
    end else if (bus.slv_req[rr_q].ac_valid) begin
      grant_s = rr_q;
    end else if (bus.slv_req[~rr_q].ac_valid) begin
      grant_s = ~rr_q;
    end else begin
      grant_s = rr_q;
    end
  end

  assign cr_dt_s    = cr_data_transfer(bus.mst_resp.cr_resp);
  // Full order FIFO blocks AC entirely; a same-cycle CR pop does not help.
  assign ac_valid_s = bus.slv_req[grant_s].ac_valid && !cr_full_s;
  assign ac_hs_s    = ac_valid_s && bus.mst_resp.ac_ready;
  assign cr_hs_s    = bus.mst_resp.cr_valid && mst_req_s.cr_ready;
  assign cd_hs_s    = bus.mst_resp.cd_valid && mst_req_s.cd_ready;

  // Crossbar-side request and per-requester response routing.
  always_comb begin
    mst_req_s          = '0;
    slv_resp_s         = '0;
    mst_req_s.ac_valid = ac_valid_s;
    mst_req_s.ac       = bus.slv_req[grant_s].ac;
    mst_req_s.cr_ready = bus.slv_req[cr_head_s].cr_ready && !cr_empty_s &&
                         (!cr_dt_s || !cd_full_s);
    mst_req_s.cd_ready = bus.slv_req[cd_head_s].cd_ready && !cd_empty_s;
    for (int unsigned i = 0; i < NumSnoopSrc; i++) begin
      slv_resp_s[i].ac_ready = (grant_s == ccu_snoop_src_t'(i)) && !cr_full_s &&
                               bus.mst_resp.ac_ready;
      slv_resp_s[i].cr_valid = bus.mst_resp.cr_valid && !cr_empty_s &&
                               (cr_head_s == ccu_snoop_src_t'(i));
      slv_resp_s[i].cr_resp  = bus.mst_resp.cr_resp;
      slv_resp_s[i].cd_valid = bus.mst_resp.cd_valid && !cd_empty_s &&
                               (cd_head_s == ccu_snoop_src_t'(i));
      slv_resp_s[i].cd       = bus.mst_resp.cd;
    end
  end

  assign bus.mst_req  = mst_req_s;
  assign bus.slv_resp = slv_resp_s;
  assign proto_err_o  = (bus.mst_resp.cr_valid && cr_empty_s) ||
                        (bus.mst_resp.cd_valid && cd_empty_s);
  assign outstanding_o = out_q;

  // Next-state for round-robin pointer, grant lock and outstanding count.
  always_comb begin
    rr_d       = rr_q;
    lock_d     = ac_valid_s && !bus.mst_resp.ac_ready;
    lock_idx_d = grant_s;
    out_d      = out_q;
    if (ac_hs_s) begin
      rr_d = ~grant_s;
    end else begin
      rr_d = rr_q;
    end
    case ({ac_hs_s, cr_hs_s})
      2'b10:   out_d = out_q + OutW'(1);
      2'b01:   out_d = out_q - OutW'(1);
      default: out_d = out_q;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= 1'b0;
      lock_q     <= 1'b0;
      lock_idx_q <= 1'b0;
      out_q      <= {OutW{1'b0}};
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      out_q      <= out_d;
    end
  end

  ccu_snoop_route_fifo #(.DEPTH(MAX_OUTSTANDING)) i_cr_order (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ac_hs_s),
    .data_i  (grant_s),
    .pop_i   (cr_hs_s),
    .full_o  (cr_full_s),
    .empty_o (cr_empty_s),
    .head_o  (cr_head_s)
  );

  ccu_snoop_route_fifo #(.DEPTH(MAX_CD_PENDING)) i_cd_order (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cr_hs_s && cr_dt_s),
    .data_i  (cr_head_s),
    .pop_i   (cd_hs_s && bus.mst_resp.cd.last),
    .full_o  (cd_full_s),
    .empty_o (cd_empty_s),
    .head_o  (cd_head_s)
  );

endmodule
